aes_idec_iter: RTL and testbench

Iterative AES inverse cipher that executes one inverse round per clock over a single 128-bit state register. The key length is selected by parameter (AES-128/192/256). The block sits between the expanded-key store and the decrypt datapath consumer, with valid/ready handshakes on both the input and output sides. It supersedes the fixed, purely combinational final-round stage: every round, including the final one, is sequenced inside this block.

---
 rtl/aes_idec_iter_pkg.sv | 25 ++
 rtl/aes_idec_iter_if.sv | 22 ++
 rtl/aes_idec_iter_iround.sv | 91 +++++++++
 rtl/aes_idec_iter.sv | 109 ++++++++++
 tb/tb_aes_idec_iter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_idec_iter_pkg.sv
// Shared constants, FSM state type and datapath types for the iterative AES inverse cipher.

package aes_const;
    // Columns per state (fixed by AES).
    localparam int NB = 4;

    // Round count for a key of nk 32-bit words.
    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_e;
endpackage

package aes_wire;
    // 16-byte AES state, byte r+4*c is row r of column c (column-major wire order).
    typedef logic [0:15][7:0] state_t;
    // Expanded-key word; bits [31:24] hold row 0.
    typedef logic [31:0]      word_t;
endpackage

// File: rtl/aes_idec_iter_if.sv
// Ciphertext-in / plaintext-out valid/ready bus of the iterative AES inverse cipher.

interface aes_idec_iter_if;
    logic             in_valid;
    logic             in_ready;
    aes_wire::state_t in_data;
    logic             out_valid;
    logic             out_ready;
    aes_wire::state_t out_data;

    // Producer of ciphertext and consumer of plaintext.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The cipher block itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_idec_iter_iround.sv
// Combinational inverse AES round and its four steps; last=1 skips InvMixColumns.

module aes_isrow import aes_wire::*; (
    input  state_t s_i,
    output state_t s_o
);
    // Row r rotates right by r columns.
    always_comb begin
        s_o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s_o[r + 4*c] = s_i[r + 4*((c - r + 4) % 4)];
    end
endmodule

module aes_isbyte import aes_wire::*; (
    input  state_t     s_i,
    input  logic [7:0] ibox [0:255],
    output state_t     s_o
);
    // Table lookup of every state byte in the inverse S-box.
    always_comb begin
        s_o = '0;
        for (int i = 0; i < 16; i++)
            s_o[i] = ibox[s_i[i]];
    end
endmodule

module aes_arkey import aes_wire::*; (
    input  state_t s_i,
    input  word_t  rk [0:3],
    output state_t s_o
);
    // Key word c is XORed into column c, most significant byte into row 0.
    always_comb begin
        s_o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s_o[r + 4*c] = s_i[r + 4*c] ^ rk[c][31 - 8*r -: 8];
    end
endmodule

module aes_imcol import aes_wire::*; (
    input  state_t s_i,
    output state_t s_o
);
    // First row of the InvMixColumns matrix; row r is this rotated right by r.
    localparam logic [3:0] IMC [0:3] = '{4'he, 4'hb, 4'hd, 4'h9};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Each output byte is the GF(2^8) dot product of a matrix row with its column.
    always_comb begin
        s_o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    s_o[r + 4*c] ^= gmul(s_i[k + 4*c], IMC[(k - r + 4) % 4]);
    end
endmodule

module aes_iround import aes_wire::*; (
    input  state_t     s_i,
    input  word_t      rk [0:3],
    input  logic [7:0] ibox [0:255],
    input  logic       last,
    output state_t     s_o
);
    state_t sr, sb, ak, mc;

    aes_isrow  u_isrow  (.s_i(s_i), .s_o(sr));
    aes_isbyte u_isbyte (.s_i(sr), .ibox(ibox), .s_o(sb));
    aes_arkey  u_arkey  (.s_i(sb), .rk(rk), .s_o(ak));
    aes_imcol  u_imcol  (.s_i(ak), .s_o(mc));

    assign s_o = last ? ak : mc;
endmodule

// File: rtl/aes_idec_iter.sv
// Iterative AES inverse cipher: one inverse round per clock over a single 128-bit state register.

module aes_idec_iter
    import aes_const::*, aes_wire::*;
#(
    parameter int NK             = 4,
    parameter int STALL_ON_FLUSH = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    aes_idec_iter_if.slave bus,
    input  word_t          KExp [0:NB*(nr_of(NK)+1)-1],
    input  logic [7:0]     IBox [0:255]
);
    localparam int NR = nr_of(NK);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_idec_iter: NK must be 4, 6 or 8");
    end

    fsm_e       state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    state_t     st_q, st_d;
    state_t     out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;

    word_t      rk_init [0:3];
    word_t      rk_rnd  [0:3];
    state_t     init_st, rnd_st;
    logic       flush_eff, accept;

    // Round keys: the last one for the initial AddRoundKey, cnt's (or key 0 in FINAL) for the iterated round.
    always_comb begin
        for (int c = 0; c < NB; c++) begin
            rk_init[c] = KExp[NR*NB + c];
            rk_rnd[c]  = (state_q == FINAL) ? KExp[c] : KExp[int'(cnt_q)*NB + c];
        end
    end

    aes_arkey  u_init_ark (.s_i(bus.in_data), .rk(rk_init), .s_o(init_st));
    aes_iround u_iround   (.s_i(st_q), .rk(rk_rnd), .ibox(IBox), .last(state_q == FINAL), .s_o(rnd_st));

    // in_ready is the only combinational output; in DONE it follows the consumer so blocks run back-to-back.
    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign flush_eff     = flush && !(STALL_ON_FLUSH != 0 && state_q == DONE && !bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready && !flush_eff;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Next-state, round counter and datapath update.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (flush_eff) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ROUND: begin
                    st_d = rnd_st;
                    if (cnt_q == 4'd1) state_d = FINAL;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                FINAL: begin
                    out_data_d  = rnd_st;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Acceptance is only possible from IDLE or a draining DONE, so it overrides the case above.
            if (accept) begin
                st_d    = init_st;
                cnt_d   = 4'(NR - 1);
                state_d = ROUND;
            end
        end
    end

    // State, counter, cipher state and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            st_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of all the others.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_aes_idec_iter.sv
// Self-checking bench for aes_idec_iter: NK=4/6/8 instances, known-answer vectors plus handshake corner cases.

module tb_aes_idec_iter;
    import aes_const::*;
    import aes_wire::*;

    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB   = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
    localparam logic [127:0] CT_F = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_F = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_S = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_S = 128'h6bc1bee22e409f96e93d7e117393172a;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    logic   in_valid  [3];
    logic   out_ready [3];
    state_t in_data   [3];
    logic   in_ready  [3];
    logic   out_valid [3];
    state_t out_data  [3];

    word_t      kexp4 [0:43];
    word_t      kexp6 [0:51];
    word_t      kexp8 [0:59];
    word_t      kx    [0:59];
    word_t      kprev4 [0:43];
    logic [7:0] ibox  [0:255];
    logic [7:0] fsb   [0:255];

    aes_idec_iter_if bus4 ();
    aes_idec_iter_if bus6 ();
    aes_idec_iter_if bus8 ();

    assign bus4.in_valid  = in_valid[0];
    assign bus4.in_data   = in_data[0];
    assign bus4.out_ready = out_ready[0];
    assign in_ready[0]    = bus4.in_ready;
    assign out_valid[0]   = bus4.out_valid;
    assign out_data[0]    = bus4.out_data;
    assign bus6.in_valid  = in_valid[1];
    assign bus6.in_data   = in_data[1];
    assign bus6.out_ready = out_ready[1];
    assign in_ready[1]    = bus6.in_ready;
    assign out_valid[1]   = bus6.out_valid;
    assign out_data[1]    = bus6.out_data;
    assign bus8.in_valid  = in_valid[2];
    assign bus8.in_data   = in_data[2];
    assign bus8.out_ready = out_ready[2];
    assign in_ready[2]    = bus8.in_ready;
    assign out_valid[2]   = bus8.out_valid;
    assign out_data[2]    = bus8.out_data;

    aes_idec_iter #(.NK(4)) dut4 (.clock(clock), .reset(reset), .flush(flush), .bus(bus4), .KExp(kexp4), .IBox(ibox));
    aes_idec_iter #(.NK(6)) dut6 (.clock(clock), .reset(reset), .flush(flush), .bus(bus6), .KExp(kexp6), .IBox(ibox));
    aes_idec_iter #(.NK(8)) dut8 (.clock(clock), .reset(reset), .flush(flush), .bus(bus8), .KExp(kexp8), .IBox(ibox));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gm(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t subw(input word_t w);
        return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
    endfunction

    // Key schedule for instance d (NK = 4 + 2*d); key bytes left-aligned in a 256-bit value.
    task automatic load_key(input int d, input logic [255:0] key);
        int         nk;
        word_t      t;
        logic [7:0] rc;
        nk = 4 + 2*d;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) kx[i] = '0;
        for (int i = 0; i < nk; i++) kx[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < NB*(nk + 7); i++) begin
            t = kx[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            kx[i] = kx[i-nk] ^ t;
        end
        case (d)
            0:       for (int i = 0; i < 44; i++) kexp4[i] = kx[i];
            1:       for (int i = 0; i < 52; i++) kexp6[i] = kx[i];
            default: for (int i = 0; i < 60; i++) kexp8[i] = kx[i];
        endcase
    endtask

    // Count cycles until out_valid, bounded; an expired bound shows up as a wrong latency.
    task automatic wait_out(input int d, output logic [127:0] pt, output int lat);
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (out_valid[d] === 1'b1) break;
        end
        pt = out_data[d];
    endtask

    task automatic run_block(input int d, input logic [127:0] ct, output logic [127:0] pt, output int lat);
        int guard;
        guard = 0;
        while (in_ready[d] !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        in_data[d]  = ct;
        in_valid[d] = 1'b1;
        tick();
        in_valid[d] = 1'b0;
        wait_out(d, pt, lat);
    endtask

    // Expanded key must not move while the NK=4 instance is busy.
    always @(posedge clock) begin
        logic changed;
        changed = 1'b0;
        for (int i = 0; i < 44; i++)
            if (kprev4[i] !== kexp4[i]) changed = 1'b1;
        if (reset === 1'b1 && dut4.state_q != IDLE && changed)
            $error("expanded key changed while busy");
        kprev4 <= kexp4;
    end

    typedef struct {
        int           dut;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [127:0] got;
        int           lat;
        logic         seen;

        for (int i = 0; i < 256; i++) fsb[i] = sbox(8'(i));
        for (int i = 0; i < 256; i++) ibox[fsb[i]] = 8'(i);

        vt[0] = '{0, K128, CT_F, PT_F};
        vt[1] = '{1, K192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_F};
        vt[2] = '{2, K256, 128'h8ea2b7ca516745bfeafc49904b496089, PT_F};
        vt[3] = '{0, KB, CT_B, PT_B};
        vt[4] = '{0, KB, CT_S, PT_S};

        reset = 1'b0;
        flush = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            in_data[d]   = '0;
        end
        load_key(0, K128);
        load_key(1, K192);
        load_key(2, K256);

        // Reset state on all three instances.
        #12;
        for (int d = 0; d < 3; d++) begin
            check1($sformatf("reset in_ready[%0d]", d), in_ready[d], 1'b1);
            check1($sformatf("reset out_valid[%0d]", d), out_valid[d], 1'b0);
            check($sformatf("reset out_data[%0d]", d), out_data[d], '0);
        end
        reset = 1'b1;
        tick();

        // Known-answer vectors: plaintext and acceptance-to-out_valid latency of NK+6.
        for (int i = 0; i < 5; i++) begin
            tick();
            load_key(vt[i].dut, vt[i].key);
            run_block(vt[i].dut, vt[i].ct, got, lat);
            check($sformatf("vec%0d plaintext", i), got, vt[i].pt);
            check_int($sformatf("vec%0d latency", i), lat, 4 + 2*vt[i].dut + 6);
        end

        // Backpressure: result held for 5 cycles while a second ciphertext waits.
        tick();
        out_ready[0] = 1'b0;
        run_block(0, CT_B, got, lat);
        check("bp first plaintext", got, PT_B);
        in_data[0]  = CT_S;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check1("bp in_ready low", in_ready[0], 1'b0);
            check1("bp out_valid held", out_valid[0], 1'b1);
            check("bp out_data held", out_data[0], PT_B);
            tick();
        end
        out_ready[0] = 1'b1;
        #1;
        check1("bp in_ready on release", in_ready[0], 1'b1);
        tick();
        in_valid[0] = 1'b0;
        check1("bp out_valid after transfer", out_valid[0], 1'b0);
        wait_out(0, got, lat);
        check("bp queued plaintext", got, PT_S);
        check_int("bp queued latency", lat, 10);

        // Back-to-back: in_valid held, second block accepted on the transfer edge of the first.
        tick();
        in_data[0]  = CT_B;
        in_valid[0] = 1'b1;
        tick();
        in_data[0] = CT_S;
        wait_out(0, got, lat);
        check("b2b first plaintext", got, PT_B);
        check_int("b2b first latency", lat, 10);
        #1;
        check1("b2b in_ready in DONE", in_ready[0], 1'b1);
        tick();
        in_valid[0] = 1'b0;
        check1("b2b no bubble", in_ready[0], 1'b0);
        wait_out(0, got, lat);
        check("b2b second plaintext", got, PT_S);
        check_int("b2b second latency", lat, 10);

        // Flush on the 4th round edge: back to IDLE with no output.
        tick();
        load_key(0, K128);
        in_data[0]  = CT_F;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check1("flush out_valid", out_valid[0], 1'b0);
        check1("flush in_ready", in_ready[0], 1'b1);
        seen = 1'b0;
        repeat (14) begin
            tick();
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        check1("flush no output", seen, 1'b0);
        in_valid[0] = 1'b1;
        flush       = 1'b1;
        tick();
        flush       = 1'b0;
        in_valid[0] = 1'b0;
        check1("flush beats in_valid", in_ready[0], 1'b1);
        run_block(0, CT_F, got, lat);
        check("post-flush plaintext", got, PT_F);
        check_int("post-flush latency", lat, 10);

        // Asynchronous reset between edges in the middle of a block.
        tick();
        in_data[0]  = CT_F;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (5) tick();
        #3 reset = 1'b0;
        #1;
        check1("areset out_valid", out_valid[0], 1'b0);
        check1("areset in_ready", in_ready[0], 1'b1);
        check("areset out_data", out_data[0], '0);
        #2 reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        check1("areset no output", seen, 1'b0);
        run_block(0, CT_F, got, lat);
        check("post-reset plaintext", got, PT_F);
        check_int("post-reset latency", lat, 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
